// File: rtl/sha256_round_engine.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_round_engine (with sha256_k_rom, sha256_initial_constant)
//  Purpose  : Iterative SHA-256 compression datapath, one round per clock,
//             driven by an externally supplied round index and message word.
//             Includes the combinational round-constant ROM and the H0 source.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Round-constant ROM: K[address], purely combinational.
// ----------------------------------------------------------------------------
module sha256_k_rom (
   input  logic [5:0]  address,
   output logic [31:0] value
);
   // Table lookup of the 64 SHA-256 round constants
   always_comb begin
      value = 32'h0000_0000;
      case (address)
         6'd0 : value = 32'h428a2f98;  6'd1 : value = 32'h71374491;
         6'd2 : value = 32'hb5c0fbcf;  6'd3 : value = 32'he9b5dba5;
         6'd4 : value = 32'h3956c25b;  6'd5 : value = 32'h59f111f1;
         6'd6 : value = 32'h923f82a4;  6'd7 : value = 32'hab1c5ed5;
         6'd8 : value = 32'hd807aa98;  6'd9 : value = 32'h12835b01;
         6'd10: value = 32'h243185be;  6'd11: value = 32'h550c7dc3;
         6'd12: value = 32'h72be5d74;  6'd13: value = 32'h80deb1fe;
         6'd14: value = 32'h9bdc06a7;  6'd15: value = 32'hc19bf174;
         6'd16: value = 32'he49b69c1;  6'd17: value = 32'hefbe4786;
         6'd18: value = 32'h0fc19dc6;  6'd19: value = 32'h240ca1cc;
         6'd20: value = 32'h2de92c6f;  6'd21: value = 32'h4a7484aa;
         6'd22: value = 32'h5cb0a9dc;  6'd23: value = 32'h76f988da;
         6'd24: value = 32'h983e5152;  6'd25: value = 32'ha831c66d;
         6'd26: value = 32'hb00327c8;  6'd27: value = 32'hbf597fc7;
         6'd28: value = 32'hc6e00bf3;  6'd29: value = 32'hd5a79147;
         6'd30: value = 32'h06ca6351;  6'd31: value = 32'h14292967;
         6'd32: value = 32'h27b70a85;  6'd33: value = 32'h2e1b2138;
         6'd34: value = 32'h4d2c6dfc;  6'd35: value = 32'h53380d13;
         6'd36: value = 32'h650a7354;  6'd37: value = 32'h766a0abb;
         6'd38: value = 32'h81c2c92e;  6'd39: value = 32'h92722c85;
         6'd40: value = 32'ha2bfe8a1;  6'd41: value = 32'ha81a664b;
         6'd42: value = 32'hc24b8b70;  6'd43: value = 32'hc76c51a3;
         6'd44: value = 32'hd192e819;  6'd45: value = 32'hd6990624;
         6'd46: value = 32'hf40e3585;  6'd47: value = 32'h106aa070;
         6'd48: value = 32'h19a4c116;  6'd49: value = 32'h1e376c08;
         6'd50: value = 32'h2748774c;  6'd51: value = 32'h34b0bcb5;
         6'd52: value = 32'h391c0cb3;  6'd53: value = 32'h4ed8aa4a;
         6'd54: value = 32'h5b9cca4f;  6'd55: value = 32'h682e6ff3;
         6'd56: value = 32'h748f82ee;  6'd57: value = 32'h78a5636f;
         6'd58: value = 32'h84c87814;  6'd59: value = 32'h8cc70208;
         6'd60: value = 32'h90befffa;  6'd61: value = 32'ha4506ceb;
         6'd62: value = 32'hbef9a3f7;  6'd63: value = 32'hc67178f2;
         default: value = 32'h0000_0000;
      endcase
   end
endmodule

// ----------------------------------------------------------------------------
// SHA-256 initial hash value H0..H7, H0 in the most significant word.
// ----------------------------------------------------------------------------
module sha256_initial_constant (
   output logic [255:0] out
);
   localparam logic [255:0] c_H_INIT = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   assign out = c_H_INIT;
endmodule

// ----------------------------------------------------------------------------
// Round engine: working variables, 16-word message schedule and done flag.
// ----------------------------------------------------------------------------
module sha256_round_engine (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [5:0]   counter,
   input  logic [31:0]  wordIn,
   input  logic [255:0] hashIn,
   output logic         ready,
   output logic [287:0] hashOut
);
   localparam logic [5:0] c_LAST_ROUND = 6'd63;
   localparam logic [5:0] c_SCHED_LEN  = 6'd16;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   // A is held as an unresolved pair (T1, T2); the final add is deferred to
   // the next round's read so it stays off the T1/T2 critical path.
   logic [31:0] r_aa, r_ab, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
   // r_w[15] is W[t-1], r_w[0] is W[t-16]
   logic [31:0] r_w [16];
   logic        r_ready;

   logic        w_first;
   logic        w_run;
   logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
   logic [31:0] w_k;
   logic [31:0] w_sched;
   logic [31:0] w_wt;
   logic [31:0] w_t1, w_t2;

   sha256_k_rom u_k_rom (
      .address (counter),
      .value   (w_k)
   );

   assign w_first = (counter == 6'd0);
   // After round 63 the state is frozen until a new block starts at t=0
   assign w_run   = w_first || !r_ready;

   // Round-source select: seed from hashIn at t=0, else from the registers
   always_comb begin
      if (w_first) begin
         {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = hashIn;
      end else begin
         w_a = r_aa + r_ab;
         w_b = r_b;
         w_c = r_c;
         w_d = r_d;
         w_e = r_e;
         w_f = r_f;
         w_g = r_g;
         w_h = r_h;
      end
   end

   assign w_sched = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
   assign w_wt    = (counter < c_SCHED_LEN) ? wordIn : w_sched;

   assign w_t1 = w_h + bsig1(w_e) + ((w_e & w_f) ^ (~w_e & w_g)) + w_k + w_wt;
   assign w_t2 = bsig0(w_a) + ((w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c));

   // Execute one round per edge and shift W_t into the schedule
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aa    <= 32'h0;
         r_ab    <= 32'h0;
         r_b     <= 32'h0;
         r_c     <= 32'h0;
         r_d     <= 32'h0;
         r_e     <= 32'h0;
         r_f     <= 32'h0;
         r_g     <= 32'h0;
         r_h     <= 32'h0;
         r_ready <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            r_w[i] <= 32'h0;
         end
      end else if (w_run) begin
         r_aa    <= w_t1;
         r_ab    <= w_t2;
         r_b     <= w_a;
         r_c     <= w_b;
         r_d     <= w_c;
         r_e     <= w_d + w_t1;
         r_f     <= w_e;
         r_g     <= w_f;
         r_h     <= w_g;
         r_ready <= (counter == c_LAST_ROUND);
         for (int i = 0; i < 15; i++) begin
            r_w[i] <= r_w[i + 1];
         end
         r_w[15] <= w_wt;
      end
   end

   assign ready   = r_ready;
   assign hashOut = {r_aa, r_ab, r_b, r_c, r_d, r_e, r_f, r_g, r_h};
endmodule

`default_nettype wire

// File: tb/tb_sha256_round_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_round_engine
//  Purpose  : Randomised scoreboard bench for the SHA-256 round engine, with
//             directed "abc", reset, hold, ROM and initial-constant checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sha256_round_engine;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [5:0]   counter;
   logic [31:0]  wordIn;
   logic [255:0] hashIn;
   logic         ready;
   logic [287:0] hashOut;

   logic [5:0]   rom_addr;
   logic [31:0]  rom_val;
   logic [255:0] ic_out;

   int n_vec = 0;
   int n_err = 0;

   logic [255:0] exp_q [$];

   localparam logic [255:0] c_H0 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   logic [31:0] k_tab [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   sha256_round_engine dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .counter (counter),
      .wordIn  (wordIn),
      .hashIn  (hashIn),
      .ready   (ready),
      .hashOut (hashOut)
   );

   sha256_k_rom u_rom (
      .address (rom_addr),
      .value   (rom_val)
   );

   sha256_initial_constant u_ic (
      .out (ic_out)
   );

   always #5 clk = ~clk;

   // Architectural state {A..H} seen on hashOut, with A = Aa + Ab
   function automatic logic [255:0] dut_state(input logic [287:0] ho);
      logic [31:0] a;
      a = ho[287:256] + ho[255:224];
      return {a, ho[223:0]};
   endfunction

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Software SHA-256 compression: 64 rounds, no feed-forward
   function automatic logic [255:0] model(input logic [255:0] hin, input logic [31:0] m [16]);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2, s0, s1;
      for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = m[t];
         else begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
         end
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one full block: counter 0..63; words beyond t=15 are random junk
   task automatic run_block(input logic [255:0] hin, input logic [31:0] m [16], input bit push);
      if (push) exp_q.push_back(model(hin, m));
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         hashIn  = hin;
         counter = 6'(t);
         wordIn  = (t < 16) ? m[t] : $urandom;
      end
      @(negedge clk);
   endtask

   // Monitor: every rising edge of ready retires one expected block result
   logic prev_ready = 1'b0;
   always @(negedge clk) begin
      if (ready && !prev_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ready: got ready=1 expected no pending block");
         end else begin
            check("block_state", dut_state(hashOut), exp_q.pop_front());
         end
      end
      prev_ready = ready;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0]  abc [16];
      logic [31:0]  rnd [16];
      logic [255:0] hin;
      logic [255:0] abc_final;
      logic [255:0] digest;

      abc_final = {32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
                   32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894};
      for (int i = 0; i < 16; i++) abc[i] = 32'h0;
      abc[0]  = 32'h61626380;
      abc[15] = 32'h00000018;

      rst_n = 1'b0; counter = 6'd0; wordIn = 32'h0; hashIn = '0; rom_addr = 6'd0;
      #1;
      check("reset_hashout", {224'h0, hashOut[287:256]}, '0);
      check("reset_hashout_lo", hashOut[255:0], '0);
      check("reset_ready", {255'h0, ready}, '0);

      // ROM sweep and initial constant
      for (int i = 0; i < 64; i++) begin
         rom_addr = 6'(i);
         #1;
         check($sformatf("k_rom[%0d]", i), {224'h0, rom_val}, {224'h0, k_tab[i]});
      end
      check("initial_constant", ic_out, c_H0);

      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-block clears state without a clock edge
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         hashIn = c_H0; counter = 6'(t); wordIn = abc[t];
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midblock_reset_state", hashOut[255:0], '0);
      check("midblock_reset_a", {224'h0, hashOut[287:256]}, '0);
      check("midblock_reset_ready", {255'h0, ready}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // "abc" round 0
      @(negedge clk);
      hashIn = c_H0; counter = 6'd0; wordIn = 32'h61626380;
      @(negedge clk);
      check("abc_round0", dut_state(hashOut),
            {32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
             32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab});

      // "abc" full block; scoreboard checks against the model, then directly
      run_block(c_H0, abc, 1'b1);
      check("abc_ready", {255'h0, ready}, {255'h0, 1'b1});
      check("abc_final", dut_state(hashOut), abc_final);
      for (int i = 0; i < 8; i++)
         digest[255 - 32*i -: 32] = abc_final[255 - 32*i -: 32] + c_H0[255 - 32*i -: 32];
      check("abc_digest_dut", digest,
            {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
             32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad});
      for (int i = 0; i < 8; i++)
         digest[255 - 32*i -: 32] = dut_state(hashOut) >> (224 - 32*i);
      for (int i = 0; i < 8; i++)
         digest[255 - 32*i -: 32] = digest[255 - 32*i -: 32] + c_H0[255 - 32*i -: 32];
      check("abc_digest_hw", digest,
            {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
             32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad});

      // Hold at counter=63: nothing changes
      for (int i = 0; i < 10; i++) begin
         wordIn = $urandom;
         @(negedge clk);
         check("hold_state", dut_state(hashOut), abc_final);
         check("hold_ready", {255'h0, ready}, {255'h0, 1'b1});
      end

      // counter=0 restarts: ready drops and round 0 executes
      hashIn = c_H0; counter = 6'd0; wordIn = 32'h61626380;
      @(negedge clk);
      check("restart_ready", {255'h0, ready}, '0);
      check("restart_round0", dut_state(hashOut),
            {32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
             32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab});

      // Random blocks, random chaining values on odd blocks
      for (int b = 0; b < 110; b++) begin
         for (int i = 0; i < 16; i++) rnd[i] = $urandom;
         if (b[0]) begin
            for (int i = 0; i < 8; i++) hin[255 - 32*i -: 32] = $urandom;
         end else begin
            hin = c_H0;
         end
         run_block(hin, rnd, 1'b1);
      end

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", {224'h0, 32'(exp_q.size())}, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
